// File: rtl/instruction_decoder.sv
// Registered decoder for the teaching CPU: splits an instruction byte into an
// opcode class (one-hot) and two register indices, all valid one clock later.
module instruction_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  output logic [2:0] operand_a,
  output logic [2:0] operand_b,
  output logic [4:0] instr_flag
);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam logic [4:0] FLAG_MOV = 5'b00001;
  localparam logic [4:0] FLAG_ADD = 5'b00010;
  localparam logic [4:0] FLAG_SUB = 5'b00100;
  localparam logic [4:0] FLAG_AND = 5'b01000;
  localparam logic [4:0] FLAG_NOP = 5'b10000;

  logic [1:0] w_opcode;
  logic [2:0] w_operand_a;
  logic [2:0] w_operand_b;
  logic       w_is_nop;
  logic [4:0] w_flag;

  logic [2:0] r_operand_a;
  logic [2:0] r_operand_b;
  logic [4:0] r_instr_flag;

  assign w_opcode    = in[7:6];
  assign w_operand_a = in[5:3];
  assign w_operand_b = in[2:0];
  // The all-zero byte would otherwise decode as MOV r0,r0; it is reserved as NOP.
  assign w_is_nop    = (in == 8'h00);

  always_comb begin
    w_flag = FLAG_MOV;
    if (w_is_nop) begin
      w_flag = FLAG_NOP;
    end else begin
      case (w_opcode)
        OP_MOV:  w_flag = FLAG_MOV;
        OP_ADD:  w_flag = FLAG_ADD;
        OP_SUB:  w_flag = FLAG_SUB;
        OP_AND:  w_flag = FLAG_AND;
        default: w_flag = FLAG_MOV;
      endcase
    end
  end

  // All-zero flags mark "nothing decoded yet" until the first edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_operand_a  <= 3'b000;
      r_operand_b  <= 3'b000;
      r_instr_flag <= 5'b00000;
    end else begin
      r_operand_a  <= w_operand_a;
      r_operand_b  <= w_operand_b;
      r_instr_flag <= w_flag;
    end
  end

  assign operand_a  = r_operand_a;
  assign operand_b  = r_operand_b;
  assign instr_flag = r_instr_flag;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: reset, per-class decode, latency,
// mid-stream reset and a full 256-value sweep against a reference model.
module tb_instruction_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic [2:0] operand_a;
  logic [2:0] operand_b;
  logic [4:0] instr_flag;

  int errors;
  int checks;

  logic [10:0] exp_q[$];

  instruction_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .instr_flag (instr_flag)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
    in  = 8'h00;
  end

  // Driver: outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [2:0] ea,
                           input logic [2:0] eb, input logic [4:0] ef);
    checks++;
    if (operand_a !== ea || operand_b !== eb || instr_flag !== ef) begin
      errors++;
      $display("FAIL %s: got a=%b b=%b flag=%b, expected a=%b b=%b flag=%b",
               name, operand_a, operand_b, instr_flag, ea, eb, ef);
    end
  endtask

  task automatic apply(input string name, input logic [7:0] v,
                       input logic [2:0] ea, input logic [2:0] eb, input logic [4:0] ef);
    in = v;
    tick();
    check_out(name, ea, eb, ef);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in  = 8'hFF;
    tick();
    check_out("reset_edge1", 3'b000, 3'b000, 5'b00000);
    tick();
    check_out("reset_edge2", 3'b000, 3'b000, 5'b00000);
    rst = 1'b0;
  endtask

  task automatic test_mov();
    apply("mov_08", 8'b00001000, 3'b001, 3'b000, 5'b00001);
    apply("mov_09", 8'b00001001, 3'b001, 3'b001, 5'b00001);
    apply("mov_01", 8'b00000001, 3'b000, 3'b001, 5'b00001);
  endtask

  task automatic test_add();
    apply("add_41", 8'b01000001, 3'b000, 3'b001, 5'b00010);
    apply("add_61", 8'b01100001, 3'b100, 3'b001, 5'b00010);
  endtask

  task automatic test_sub_and_nop();
    apply("sub_ba", 8'b10111010, 3'b111, 3'b010, 5'b00100);
    apply("and_d5", 8'b11010101, 3'b010, 3'b101, 5'b01000);
    apply("nop_00", 8'h00,       3'b000, 3'b000, 5'b10000);
  endtask

  task automatic test_latency();
    apply("lat_first", 8'h08, 3'b001, 3'b000, 5'b00001);
    #3;
    in = 8'hC7;
    #2;
    check_out("lat_hold", 3'b001, 3'b000, 5'b00001);
    tick();
    check_out("lat_next", 3'b000, 3'b111, 5'b01000);
  endtask

  task automatic test_mid_reset();
    apply("pre_reset", 8'h5A, 3'b011, 3'b010, 5'b00010);
    rst = 1'b1;
    in  = 8'b01100001;
    tick();
    check_out("mid_reset", 3'b000, 3'b000, 5'b00000);
    rst = 1'b0;
    tick();
    check_out("post_reset", 3'b100, 3'b001, 5'b00010);
  endtask

  function automatic logic [4:0] ref_flag(input logic [7:0] v);
    if (v == 8'h00) return 5'b10000;
    case (v[7:6])
      2'b00:   return 5'b00001;
      2'b01:   return 5'b00010;
      2'b10:   return 5'b00100;
      default: return 5'b01000;
    endcase
  endfunction

  task automatic test_back_to_back();
    logic [10:0] e;
    logic [7:0]  v;
    for (int i = 0; i < 256; i++) begin
      v  = 8'(i);
      in = v;
      exp_q.push_back({v[5:3], v[2:0], ref_flag(v)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({operand_a, operand_b, instr_flag} !== e) begin
        errors++;
        $display("FAIL sweep_%0d: got a=%b b=%b flag=%b, expected a=%b b=%b flag=%b",
                 i, operand_a, operand_b, instr_flag, e[10:8], e[7:5], e[4:0]);
      end
      checks++;
      if (!$onehot(instr_flag)) begin
        errors++;
        $display("FAIL onehot_%0d: got flag=%b, expected exactly one bit set", i, instr_flag);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mov();
    test_add();
    test_sub_and_nop();
    test_latency();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
